// File: rtl/dmem_mmio_if.sv
// Bus bundle between the single-cycle core side and the data-memory/MMIO stage.
// Carries load/store access signals and the TX FIFO valid/ready drain port.
interface dmem_mmio_if;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output memwrite, addr, writedata, out_ready,
    input  readdata, out_data, out_valid
  );

  modport slave (
    input  memwrite, addr, writedata, out_ready,
    output readdata, out_data, out_valid
  );
endinterface

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO window (TX FIFO, status, cycle counter) with zero-latency reads.
// Optional macro DMEM_CLEAR_ON_RESET_EN: reset also zeroes every RAM word.
module dmem_mmio #(
  parameter int          MEM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
  input logic        clk,
  input logic        reset,
  dmem_mmio_if.slave bus
);

  localparam int          LP_AW      = $clog2(MEM_WORDS);
  localparam int          LP_FW      = $clog2(FIFO_DEPTH);
  localparam logic [29:0] LP_TX_WORD = MMIO_BASE[31:2];
  localparam logic [29:0] LP_ST_WORD = LP_TX_WORD + 30'd1;
  localparam logic [29:0] LP_CY_WORD = LP_TX_WORD + 30'd2;
  localparam logic [LP_FW:0] LP_FULL = (LP_FW + 1)'(FIFO_DEPTH);

  logic [31:0]      r_mem [MEM_WORDS];
  logic [31:0]      r_fifo [FIFO_DEPTH];
  logic [LP_FW-1:0] r_head;
  logic [LP_FW-1:0] r_tail;
  logic [LP_FW:0]   r_count;
  logic             r_overflow;
  logic [31:0]      r_cycle;

  logic [29:0]      w_word;
  logic [LP_AW-1:0] w_ram_idx;
  logic             w_sel_ram;
  logic             w_sel_tx;
  logic             w_sel_status;
  logic             w_sel_cycle;
  logic             w_wr_ram;
  logic             w_wr_tx;
  logic             w_wr_status;
  logic             w_wr_cycle;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [31:0]      w_rdata;
  logic             w_unused_lsb;

  // Byte offset within a word never affects decode.
  assign w_unused_lsb = ^bus.addr[1:0];

  assign w_word       = bus.addr[31:2];
  assign w_ram_idx    = bus.addr[LP_AW+1:2];
  assign w_sel_ram    = (bus.addr[31:LP_AW+2] == '0);
  assign w_sel_tx     = (w_word == LP_TX_WORD);
  assign w_sel_status = (w_word == LP_ST_WORD);
  assign w_sel_cycle  = (w_word == LP_CY_WORD);

  assign w_wr_ram    = bus.memwrite & w_sel_ram;
  assign w_wr_tx     = bus.memwrite & w_sel_tx;
  assign w_wr_status = bus.memwrite & w_sel_status;
  assign w_wr_cycle  = bus.memwrite & w_sel_cycle;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_FULL);
  assign w_pop   = !w_empty && bus.out_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign w_push  = w_wr_tx && (!w_full || w_pop);
  assign w_drop  = w_wr_tx && w_full && !w_pop;

  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ram) begin
      r_mem[w_ram_idx] <= bus.writedata;
    end
`else
    if (!reset && w_wr_ram) begin
      r_mem[w_ram_idx] <= bus.writedata;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_fifo[r_tail] <= bus.writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_wr_status) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle <= '0;
    end else if (w_wr_cycle) begin
      r_cycle <= bus.writedata;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel_ram) begin
      w_rdata = r_mem[w_ram_idx];
    end else if (w_sel_status) begin
      w_rdata = {29'b0, r_overflow, w_full, w_empty};
    end else if (w_sel_cycle) begin
      w_rdata = r_cycle;
    end
  end

  assign bus.readdata  = w_rdata;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_empty ? 32'h0 : r_fifo[r_head];

endmodule
